// File: rtl/alu4_shift_mul.sv
`default_nettype none

// ============================================================================
// Module   : alu4_fa
// Purpose  : One-bit full adder built only from AND / XOR / OR gates.
// Ports    : a_i, b_i, ci_i -> sum and carry inputs
//            s_o            -> sum bit
//            co_o           -> carry out
// Revision : 1.0 - initial release
// ============================================================================
module alu4_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    logic w_axb;

    assign w_axb = a_i ^ b_i;
    assign s_o   = w_axb ^ ci_i;
    assign co_o  = (a_i & b_i) | (ci_i & w_axb);

endmodule

// ============================================================================
// Module   : alu4_ripple_add
// Purpose  : 4-bit ripple-carry adder made from alu4_fa cells.
// Ports    : a_i[3:0], b_i[3:0] -> addends
//            ci_i               -> carry in
//            s_o[3:0]           -> sum
//            co_o               -> carry out of bit 3
// Revision : 1.0 - initial release
// ============================================================================
module alu4_ripple_add (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic       co_o
);

    // w_carry[k] is the carry into bit k; w_carry[4] is the final carry out.
    logic [4:0] w_carry;

    assign w_carry[0] = ci_i;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_bit
            alu4_fa u_fa (
                .a_i  (a_i[gi]),
                .b_i  (b_i[gi]),
                .ci_i (w_carry[gi]),
                .s_o  (s_o[gi]),
                .co_o (w_carry[gi+1])
            );
        end
    endgenerate

    assign co_o = w_carry[4];

endmodule

// ============================================================================
// Module   : alu4_shift_mul
// Purpose  : Multi-cycle unsigned 4x4 shift-and-add multiplier. A start
//            pulse in IDLE captures the operands; four RUN iterations build
//            the 8-bit product, which is published on entry to DONE together
//            with a one-cycle done pulse.
// Ports    : clk        -> system clock, rising-edge active
//            reset_n    -> asynchronous active-low reset
//            start      -> request, honoured only in IDLE
//            a[3:0]     -> multiplicand (captured on acceptance)
//            b[3:0]     -> multiplier   (captured on acceptance)
//            busy       -> high whenever not IDLE
//            done       -> one-cycle pulse, product valid
//            p[7:0]     -> product register, held until next completion
// Revision : 1.0 - initial release
// ============================================================================
module alu4_shift_mul (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] p
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] C_LAST_ITER = 3'd3;

    state_t     state_q, state_d;
    logic [3:0] m_q,     m_d;      // multiplicand
    logic [3:0] acc_q,   acc_d;    // accumulator (high product half)
    logic       c_q,     c_d;      // adder carry
    logic [3:0] q_q,     q_d;      // multiplier / low product half
    logic [2:0] cnt_q,   cnt_d;    // iteration count
    logic [7:0] p_q,     p_d;      // published product

    logic [3:0] w_addend;
    logic [3:0] w_sum;
    logic       w_sum_co;

    // The multiplicand is only added when the current multiplier LSB is set;
    // gating with AND keeps the datapath purely in gate primitives.
    assign w_addend = m_q & {4{q_q[0]}};

    // c_q is always zero at the start of an iteration (it is shifted out each
    // cycle), so feeding it as carry-in leaves the sum A + (Q0 ? M : 0).
    alu4_ripple_add u_add (
        .a_i  (acc_q),
        .b_i  (w_addend),
        .ci_i (c_q),
        .s_o  (w_sum),
        .co_o (w_sum_co)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        c_d     = c_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = 4'd0;
                    c_d     = 1'b0;
                    cnt_d   = 3'd0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // {C,A,Q} shifted right by one as a single 9-bit value; the
                // adder carry becomes the new accumulator MSB so it is never lost.
                acc_d = {w_sum_co, w_sum[3:1]};
                q_d   = {w_sum[0], q_q[3:1]};
                c_d   = 1'b0;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == C_LAST_ITER) begin
                    state_d = S_DONE;
                    p_d     = {acc_d, q_d};
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            m_q     <= 4'd0;
            acc_q   <= 4'd0;
            c_q     <= 1'b0;
            q_q     <= 4'd0;
            cnt_q   <= 3'd0;
            p_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // Status decoded straight from the state register so both outputs clear
    // the instant reset is asserted.
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign p    = p_q;

endmodule

`default_nettype wire
